// File: rtl/ram_burst_master_if.sv
// Bundle of the command, write-stream, read-stream and RAM-port signals
// of ram_burst_master; modport master is the burst engine's view, slave the environment's.
interface ram_burst_master_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int LEN_W = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             i_Cmd_Valid;
   logic             o_Cmd_Ready;
   logic             i_Cmd_Wr;
   logic [AW-1:0]    i_Cmd_Addr;
   logic [LEN_W-1:0] i_Cmd_Len;
   logic             i_Wr_Valid;
   logic             o_Wr_Ready;
   logic [WIDTH-1:0] i_Wr_Data;
   logic             o_Rd_Valid;
   logic             i_Rd_Ready;
   logic [WIDTH-1:0] o_Rd_Data;
   logic [AW-1:0]    o_Ram_Addr;
   logic             o_Ram_Wr_DV;
   logic [WIDTH-1:0] o_Ram_Wr_Data;
   logic             o_Ram_Rd_En;
   logic             i_Ram_Rd_DV;
   logic [WIDTH-1:0] i_Ram_Rd_Data;
   logic             o_Busy;
   logic             o_Done;

   modport master (
      input  i_Cmd_Valid, i_Cmd_Wr, i_Cmd_Addr, i_Cmd_Len,
      input  i_Wr_Valid, i_Wr_Data, i_Rd_Ready,
      input  i_Ram_Rd_DV, i_Ram_Rd_Data,
      output o_Cmd_Ready, o_Wr_Ready, o_Rd_Valid, o_Rd_Data,
      output o_Ram_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_En,
      output o_Busy, o_Done
   );

   modport slave (
      output i_Cmd_Valid, i_Cmd_Wr, i_Cmd_Addr, i_Cmd_Len,
      output i_Wr_Valid, i_Wr_Data, i_Rd_Ready,
      output i_Ram_Rd_DV, i_Ram_Rd_Data,
      input  o_Cmd_Ready, o_Wr_Ready, o_Rd_Valid, o_Rd_Data,
      input  o_Ram_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_En,
      input  o_Busy, o_Done
   );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port RAM: sequences incrementing addresses,
// streams write words in and read words out through a 2-entry output buffer.
// Ports: i_Clk, i_Rst_L (async, active-low), bus (ram_burst_master_if.master).
module ram_burst_master #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int LEN_W = 8
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   ram_burst_master_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0]  ONE_A = 1;
   localparam logic [LEN_W:0] ONE_R = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t           r_State;
   logic [AW-1:0]    r_Addr;
   logic [LEN_W:0]   r_Rem;
   logic             r_Done;
   logic             r_Inflight;
   logic [WIDTH-1:0] r_Buf [2];
   logic             r_Wptr;
   logic             r_Rptr;
   logic [1:0]       r_Count;

   logic             w_Pop;
   logic             w_Push;
   logic             w_Wr_Beat;
   logic             w_Rd_Issue;
   logic [2:0]       w_Occ;

   assign w_Pop = (r_Count != 2'd0) & bus.i_Rd_Ready;

   // Occupancy the buffer will have once the in-flight word lands,
   // net of this cycle's pop; keeps the buffer from ever overflowing.
   assign w_Occ = {1'b0, r_Count} + {2'b0, r_Inflight} - {2'b0, w_Pop};

   assign w_Rd_Issue = (r_State == S_READ) & (r_Rem != '0)
                     & (w_Occ < 3'd2);
   assign w_Wr_Beat  = (r_State == S_WRITE) & bus.i_Wr_Valid;
   assign w_Push     = bus.i_Ram_Rd_DV
                     & ((r_State == S_READ) | (r_State == S_DRAIN));

   assign bus.o_Cmd_Ready   = (r_State == S_IDLE);
   assign bus.o_Wr_Ready    = (r_State == S_WRITE);
   assign bus.o_Busy        = (r_State != S_IDLE);
   assign bus.o_Done        = r_Done;
   assign bus.o_Ram_Addr    = r_Addr;
   assign bus.o_Ram_Wr_Data = bus.i_Wr_Data;
   assign bus.o_Ram_Wr_DV   = w_Wr_Beat;
   assign bus.o_Ram_Rd_En   = w_Rd_Issue;
   assign bus.o_Rd_Valid    = (r_Count != 2'd0);
   assign bus.o_Rd_Data     = r_Buf[r_Rptr];

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State <= S_IDLE;
         r_Addr  <= '0;
         r_Rem   <= '0;
         r_Done  <= 1'b0;
      end else begin
         r_Done <= 1'b0;
         unique case (r_State)
            S_IDLE: begin
               if (bus.i_Cmd_Valid) begin
                  r_Addr  <= bus.i_Cmd_Addr;
                  r_Rem   <= {1'b0, bus.i_Cmd_Len} + ONE_R;
                  r_State <= bus.i_Cmd_Wr ? S_WRITE : S_READ;
               end
            end
            S_WRITE: begin
               if (w_Wr_Beat) begin
                  r_Addr <= r_Addr + ONE_A;
                  r_Rem  <= r_Rem - ONE_R;
                  if (r_Rem == ONE_R) begin
                     r_State <= S_IDLE;
                     r_Done  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (w_Rd_Issue) begin
                  r_Addr <= r_Addr + ONE_A;
                  r_Rem  <= r_Rem - ONE_R;
                  if (r_Rem == ONE_R)
                     r_State <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!r_Inflight && r_Count == 2'd0) begin
                  r_State <= S_IDLE;
                  r_Done  <= 1'b1;
               end
            end
            default: r_State <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Inflight <= 1'b0;
         r_Buf[0]   <= '0;
         r_Buf[1]   <= '0;
         r_Wptr     <= 1'b0;
         r_Rptr     <= 1'b0;
         r_Count    <= 2'd0;
      end else begin
         r_Inflight <= w_Rd_Issue;
         if (w_Push) begin
            r_Buf[r_Wptr] <= bus.i_Ram_Rd_Data;
            r_Wptr        <= ~r_Wptr;
         end
         if (w_Pop)
            r_Rptr <= ~r_Rptr;
         r_Count <= r_Count + {1'b0, w_Push} - {1'b0, w_Pop};
      end
   end

   a_no_overflow : assert property (
      @(posedge i_Clk) disable iff (!i_Rst_L)
      !(w_Push && !w_Pop && r_Count == 2'd2)
   );

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM;
// bursts, backpressure, address wrap, mid-burst reset, back-to-back commands.
module tb_ram_burst_master;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tot = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ram_burst_master_if #(.WIDTH(16), .DEPTH(256), .LEN_W(8)) bus ();

   ram_burst_master #(.WIDTH(16), .DEPTH(256), .LEN_W(8)) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .bus     (bus.master)
   );

   logic [15:0] mem [256];

   always @(posedge clk) begin
      if (bus.o_Ram_Wr_DV)
         mem[bus.o_Ram_Addr] <= bus.o_Ram_Wr_Data;
      bus.i_Ram_Rd_DV <= bus.o_Ram_Rd_En;
      if (bus.o_Ram_Rd_En)
         bus.i_Ram_Rd_Data <= mem[bus.o_Ram_Addr];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_crdy"}, bus.o_Cmd_Ready, 1);
      chk({tag, "_busy"}, bus.o_Busy, 0);
      chk({tag, "_done"}, bus.o_Done, 0);
      chk({tag, "_rvld"}, bus.o_Rd_Valid, 0);
      chk({tag, "_wrdy"}, bus.o_Wr_Ready, 0);
      chk({tag, "_rden"}, bus.o_Ram_Rd_En, 0);
      chk({tag, "_wrdv"}, bus.o_Ram_Wr_DV, 0);
   endtask

   task automatic wr_burst(input logic [7:0] a, input logic [7:0] len,
                           input logic [15:0] d0, input int gap,
                           input bit skip_cmd);
      logic [7:0] ea;
      if (!skip_cmd) begin
         @(negedge clk);
         bus.i_Cmd_Valid = 1'b1;
         bus.i_Cmd_Wr    = 1'b1;
         bus.i_Cmd_Addr  = a;
         bus.i_Cmd_Len   = len;
         #1 chk("wr_cmd_rdy", bus.o_Cmd_Ready, 1);
      end
      @(negedge clk);
      bus.i_Cmd_Valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         for (int g = 0; g < gap; g++) begin
            bus.i_Wr_Valid = 1'b0;
            #1;
            chk("wr_gap_dv", bus.o_Ram_Wr_DV, 0);
            chk("wr_gap_busy", bus.o_Busy, 1);
            @(negedge clk);
         end
         bus.i_Wr_Valid = 1'b1;
         bus.i_Wr_Data  = d0 + 16'(i);
         ea = a + 8'(i);
         #1;
         chk("wr_rdy", bus.o_Wr_Ready, 1);
         chk("wr_dv", bus.o_Ram_Wr_DV, 1);
         chk("wr_addr", bus.o_Ram_Addr, ea);
         chk("wr_done_early", bus.o_Done, 0);
         @(negedge clk);
      end
      bus.i_Wr_Valid = 1'b0;
      #1;
      chk("wr_done", bus.o_Done, 1);
      chk("wr_idle_rdy", bus.o_Cmd_Ready, 1);
      for (int i = 0; i <= int'(len); i++) begin
         ea = a + 8'(i);
         chk("wr_mem", mem[ea], d0 + 16'(i));
      end
      @(negedge clk);
      #1 chk("wr_done_once", bus.o_Done, 0);
   endtask

   // stall=1 drives i_Rd_Ready as 1,0,0,1,0,0...; abort_at>0 returns
   // right after that many pops; chain issues a write in the done cycle.
   task automatic rd_burst(input logic [7:0] a, input logic [7:0] len,
                           input logic [15:0] d0, input bit stall,
                           input int abort_at, input bit chain);
      int k;
      int iss;
      bit prev_stall;
      bit fin;
      logic [15:0] prev_d;
      logic [7:0] ea;
      k = 0;
      iss = 0;
      prev_stall = 1'b0;
      fin = 1'b0;
      prev_d = '0;
      @(negedge clk);
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Cmd_Wr    = 1'b0;
      bus.i_Cmd_Addr  = a;
      bus.i_Cmd_Len   = len;
      #1 chk("rd_cmd_rdy", bus.o_Cmd_Ready, 1);
      @(negedge clk);
      bus.i_Cmd_Valid = 1'b0;
      for (int t = 1; t < 80 && !fin; t++) begin
         bus.i_Rd_Ready = stall ? ((t % 3) == 1) : 1'b1;
         #1;
         if (prev_stall) begin
            chk("rd_hold_v", bus.o_Rd_Valid, 1);
            chk("rd_hold_d", bus.o_Rd_Data, prev_d);
         end
         chk("rd_buf_bound", (iss - k) <= 2, 1);
         if (bus.o_Ram_Rd_En) begin
            ea = a + 8'(iss);
            chk("rd_addr", bus.o_Ram_Addr, ea);
            chk("rd_no_wr", bus.o_Ram_Wr_DV, 0);
            iss++;
         end
         prev_stall = bus.o_Rd_Valid & !bus.i_Rd_Ready;
         prev_d = bus.o_Rd_Data;
         if (bus.o_Rd_Valid && bus.i_Rd_Ready) begin
            chk("rd_data", bus.o_Rd_Data, d0 + 16'(k));
            if (!stall)
               chk("rd_cycle", t, 3 + k);
            k++;
            if (abort_at != 0 && k == abort_at)
               fin = 1'b1;
         end
         if (bus.o_Done) begin
            chk("rd_count", k, int'(len) + 1);
            chk("rd_issued", iss, int'(len) + 1);
            if (!stall)
               chk("rd_done_cyc", t, 5 + int'(len));
            fin = 1'b1;
            if (chain) begin
               bus.i_Cmd_Valid = 1'b1;
               bus.i_Cmd_Wr    = 1'b1;
               bus.i_Cmd_Addr  = 8'h40;
               bus.i_Cmd_Len   = 8'd1;
               #1 chk("b2b_rdy", bus.o_Cmd_Ready, 1);
            end
         end
         if (!fin)
            @(negedge clk);
      end
      if (!fin)
         chk("rd_timeout", 0, 1);
      bus.i_Rd_Ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = '0;
      bus.i_Cmd_Valid   = 1'b0;
      bus.i_Cmd_Wr      = 1'b0;
      bus.i_Cmd_Addr    = '0;
      bus.i_Cmd_Len     = '0;
      bus.i_Wr_Valid    = 1'b0;
      bus.i_Wr_Data     = '0;
      bus.i_Rd_Ready    = 1'b0;
      bus.i_Ram_Rd_DV   = 1'b0;
      bus.i_Ram_Rd_Data = '0;

      @(negedge clk);
      #1 chk_idle_outs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("post_rst_done", bus.o_Done, 0);
         @(negedge clk);
      end

      wr_burst(8'h10, 8'd3, 16'h00A0, 0, 1'b0);
      rd_burst(8'h10, 8'd3, 16'h00A0, 1'b0, 0, 1'b0);
      rd_burst(8'h10, 8'd3, 16'h00A0, 1'b1, 0, 1'b0);

      wr_burst(8'hFE, 8'd3, 16'h0001, 0, 1'b0);
      rd_burst(8'hFE, 8'd3, 16'h0001, 1'b0, 0, 1'b0);

      rd_burst(8'h10, 8'd3, 16'h00A0, 1'b0, 2, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_idle_outs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mid_rst_done", bus.o_Done, 0);
         chk("mid_rst_busy", bus.o_Busy, 0);
         @(negedge clk);
      end
      rd_burst(8'h10, 8'd0, 16'h00A0, 1'b0, 0, 1'b0);

      rd_burst(8'h10, 8'd0, 16'h00A0, 1'b0, 0, 1'b1);
      wr_burst(8'h40, 8'd1, 16'h0055, 5, 1'b1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
